// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM-like port arbiter.
// The owner encoding is also the bit stored in the in-order owner FIFO.
package sram_req_arbiter_pkg;

   localparam int SRAM_SIZE_WID = 2;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Address-phase request fields that are muxed onto the shared memory port.
   typedef struct packed {
      logic                     wr;
      logic [SRAM_SIZE_WID-1:0] size;
      logic [3:0]               wstrb;
      logic [31:0]              addr;
      logic [31:0]              wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_owner_fifo.sv
// One-bit synchronous FIFO holding the owner of every accepted request,
// in issue order. Pushes are ignored when full and pops when empty.
module sram_owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_bit,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_bit;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pointers wrap naturally; only the count needs to see push and pop together.
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates the inst and data SRAM-like ports onto one memory port, with data
// priority, an inst anti-starvation limit and in-order response routing.
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     inst_req,
   input  logic                     inst_wr,
   input  logic [SRAM_SIZE_WID-1:0] inst_size,
   input  logic [3:0]               inst_wstrb,
   input  logic [31:0]              inst_addr,
   input  logic [31:0]              inst_wdata,
   output logic                     inst_addr_ok,
   output logic                     inst_data_ok,
   output logic [31:0]              inst_rdata,
   input  logic                     data_req,
   input  logic                     data_wr,
   input  logic [SRAM_SIZE_WID-1:0] data_size,
   input  logic [3:0]               data_wstrb,
   input  logic [31:0]              data_addr,
   input  logic [31:0]              data_wdata,
   output logic                     data_addr_ok,
   output logic                     data_data_ok,
   output logic [31:0]              data_rdata,
   output logic                     mem_req,
   output logic                     mem_wr,
   output logic [SRAM_SIZE_WID-1:0] mem_size,
   output logic [3:0]               mem_wstrb,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_addr_ok,
   input  logic                     mem_data_ok,
   input  logic [31:0]              mem_rdata,
   output logic                     protocol_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic          lock_q, lock_d;
   logic          owner_q, owner_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          perr_q, perr_d;

   logic          gnt_valid, gnt_side, handshake;
   logic          fifo_full, fifo_empty, fifo_head, fifo_pop;
   sram_req_t     inst_fields, data_fields, mem_fields;

   assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                          addr: inst_addr, wdata: inst_wdata};
   assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                          addr: data_addr, wdata: data_wdata};

   // Valid/ready: a requester holds *_req and its fields until *_addr_ok; a
   // transfer happens on any cycle where req and addr_ok are both high, and
   // *_data_ok is a single-cycle, unconditionally accepted response pulse.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_side  = OWNER_DATA;
      if (lock_q) begin
         gnt_valid = 1'b1;
         gnt_side  = owner_q;
      end else if (fifo_full) begin
         gnt_valid = 1'b0;
      end else if (inst_req && (starve_cnt_q == STARVE_MAX || !data_req)) begin
         gnt_valid = 1'b1;
         gnt_side  = OWNER_INST;
      end else if (data_req) begin
         gnt_valid = 1'b1;
         gnt_side  = OWNER_DATA;
      end
   end

   always_comb begin
      mem_fields   = (gnt_side == OWNER_INST) ? inst_fields : data_fields;
      mem_req      = gnt_valid && ((gnt_side == OWNER_INST) ? inst_req : data_req);
      handshake    = mem_req && mem_addr_ok;
      inst_addr_ok = gnt_valid && (gnt_side == OWNER_INST) && mem_addr_ok;
      data_addr_ok = gnt_valid && (gnt_side == OWNER_DATA) && mem_addr_ok;
   end

   assign mem_wr    = mem_fields.wr;
   assign mem_size  = mem_fields.size;
   assign mem_wstrb = mem_fields.wstrb;
   assign mem_addr  = mem_fields.addr;
   assign mem_wdata = mem_fields.wdata;

   always_comb begin
      lock_d       = mem_req && !mem_addr_ok;
      owner_d      = mem_req ? gnt_side : owner_q;
      starve_cnt_d = starve_cnt_q;
      if (!inst_req) begin
         starve_cnt_d = '0;
      end else if (handshake && gnt_side == OWNER_INST) begin
         starve_cnt_d = '0;
      end else if (handshake && starve_cnt_q != STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
      perr_d = perr_q || (mem_data_ok && fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q       <= 1'b0;
         owner_q      <= OWNER_DATA;
         starve_cnt_q <= '0;
         perr_q       <= 1'b0;
      end else begin
         lock_q       <= lock_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         perr_q       <= perr_d;
      end
   end

   assign fifo_pop     = mem_data_ok && !fifo_empty;
   assign inst_data_ok = fifo_pop && (fifo_head == OWNER_INST);
   assign data_data_ok = fifo_pop && (fifo_head == OWNER_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign protocol_err = perr_q;

   sram_owner_fifo #(
      .DEPTH(OUTSTANDING)
   ) u_owner_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (handshake),
      .push_bit(gnt_side),
      .pop     (fifo_pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a per-cycle vector table followed by
// a hand-written lock-on-inst sequence, all expectations computed by hand.
module tb_sram_req_arbiter;

   localparam logic [31:0] I_ADDR  = 32'h0000_1000;
   localparam logic [31:0] D_ADDR  = 32'h1C00_0004;
   localparam logic [31:0] I_WDATA = 32'h1111_1111;
   localparam logic [31:0] D_WDATA = 32'h2222_2222;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_req_arbiter #(
      .OUTSTANDING (2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .protocol_err(protocol_err)
   );

   typedef struct {
      logic        rst, ireq, dreq, maok, mdok;
      logic [31:0] rdata;
      logic        e_mreq, e_sel, e_iaok, e_daok, e_idok, e_ddok, e_perr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, ireq, dreq, maok, mdok, input logic [31:0] rdata,
                      input logic e_mreq, e_sel, e_iaok, e_daok, e_idok, e_ddok, e_perr);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.maok = maok; v.mdok = mdok;
      v.rdata = rdata; v.e_mreq = e_mreq; v.e_sel = e_sel; v.e_iaok = e_iaok;
      v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_perr = e_perr;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset       = v.rst;
      inst_req    = v.ireq;
      data_req    = v.dreq;
      mem_addr_ok = v.maok;
      mem_data_ok = v.mdok;
      mem_rdata   = v.rdata;
   endtask

   task automatic check_vec(input vec_t v, input int idx);
      chk("mem_req", idx, 32'(mem_req), 32'(v.e_mreq));
      chk("inst_addr_ok", idx, 32'(inst_addr_ok), 32'(v.e_iaok));
      chk("data_addr_ok", idx, 32'(data_addr_ok), 32'(v.e_daok));
      chk("inst_data_ok", idx, 32'(inst_data_ok), 32'(v.e_idok));
      chk("data_data_ok", idx, 32'(data_data_ok), 32'(v.e_ddok));
      chk("protocol_err", idx, 32'(protocol_err), 32'(v.e_perr));
      if (v.e_mreq) begin
         chk("mem_addr", idx, mem_addr, v.e_sel ? D_ADDR : I_ADDR);
         chk("mem_wdata", idx, mem_wdata, v.e_sel ? D_WDATA : I_WDATA);
         chk("mem_size", idx, 32'(mem_size), v.e_sel ? 32'd1 : 32'd2);
         chk("mem_wstrb", idx, 32'(mem_wstrb), v.e_sel ? 32'h3 : 32'hF);
      end
      if (v.e_idok) chk("inst_rdata", idx, inst_rdata, v.rdata);
      if (v.e_ddok) chk("data_rdata", idx, data_rdata, v.rdata);
   endtask

   task automatic step(input vec_t v, input int idx);
      drive(v);
      #2;
      check_vec(v, idx);
      @(negedge clk);
   endtask

   initial begin
      vec_t h;
      reset = 1'b1;
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
      inst_addr = I_ADDR; inst_wdata = I_WDATA;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd1; data_wstrb = 4'h3;
      data_addr = D_ADDR; data_wdata = D_WDATA;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

      //  rst ireq dreq maok mdok rdata           mreq sel iaok daok idok ddok perr
      // reset state
      add(0, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 0);
      // data-only read, response two cycles later
      add(0, 0, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 32'hDEAD_BEEF,          0, 0, 0, 0, 0, 1, 0);
      // both requesting, memory always ready: D,D,D,D,I,D
      add(0, 1, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0001,          1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0002,          1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0003,          1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0004,          1, 0, 1, 0, 0, 1, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0005,          1, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 1, 32'h0000_0006,          0, 0, 0, 0, 0, 1, 0);
      // build starve_cnt to 3, then stall a data request for 3 cycles
      add(0, 1, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0007,          1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 1, 32'h0000_0008,          1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 1, 32'h0000_0009,          1, 1, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 32'h0,                  1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,                  1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 32'h0000_000A,          1, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_000B,          0, 0, 0, 0, 1, 0, 0);
      // fill the owner FIFO (I then D), full blocks even with a pop
      add(0, 1, 0, 1, 0, 32'h0,                  1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 32'hAAAA_0000,          0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 1, 1, 1, 32'h5555_FFFF,          1, 1, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 32'h0000_000C,          0, 0, 0, 0, 0, 1, 0);
      // response with empty FIFO: sticky protocol_err, cleared by reset
      add(0, 0, 0, 0, 1, 32'h0000_000D,          0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 0);
      // reset with two outstanding discards ownership
      add(0, 1, 0, 1, 0, 32'h0,                  1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(1, 0, 1, 1, 0, 32'h0,                  0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h0,                  1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 32'h0000_000E,          0, 0, 0, 0, 0, 1, 0);

      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vq[i]) step(vq[i], i);

      // Lock on inst: a late data request must not steal the stalled grant.
      h = vq[0];
      h.ireq = 1'b1;
      drive(h);
      #2;
      chk("lk_mem_req", 100, 32'(mem_req), 32'd1);
      chk("lk_mem_addr", 100, mem_addr, I_ADDR);
      chk("lk_inst_addr_ok", 100, 32'(inst_addr_ok), 32'd0);
      @(negedge clk);
      h.dreq = 1'b1;
      data_wr = 1'b1;
      drive(h);
      #2;
      chk("lk_hold_addr", 101, mem_addr, I_ADDR);
      chk("lk_hold_wr", 101, 32'(mem_wr), 32'd0);
      chk("lk_hold_data_addr_ok", 101, 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      h.maok = 1'b1;
      drive(h);
      #2;
      chk("lk_inst_addr_ok", 102, 32'(inst_addr_ok), 32'd1);
      chk("lk_data_addr_ok", 102, 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      h.ireq = 1'b0;
      drive(h);
      #2;
      chk("wr_data_addr_ok", 103, 32'(data_addr_ok), 32'd1);
      chk("wr_mem_wr", 103, 32'(mem_wr), 32'd1);
      chk("wr_mem_addr", 103, mem_addr, D_ADDR);
      @(negedge clk);
      h = vq[0];
      h.mdok = 1'b1;
      h.rdata = 32'h0BAD_F00D;
      drive(h);
      #2;
      chk("rsp_inst_data_ok", 104, 32'(inst_data_ok), 32'd1);
      chk("rsp_inst_rdata", 104, inst_rdata, 32'h0BAD_F00D);
      chk("rsp_data_data_ok", 104, 32'(data_data_ok), 32'd0);
      @(negedge clk);
      drive(h);
      #2;
      chk("wrsp_data_data_ok", 105, 32'(data_data_ok), 32'd1);
      chk("wrsp_inst_data_ok", 105, 32'(inst_data_ok), 32'd0);
      @(negedge clk);
      drive(vq[0]);
      #2;
      chk("end_protocol_err", 106, 32'(protocol_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
